// File: rtl/rgu_apb_master.sv
// rgu_apb_master: single-outstanding APB requester for the RGU register bus.
// It rejects misaligned commands locally and aborts ACCESS after TIMEOUT wait states.
module rgu_apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d, to_q, to_d;
  logic              expire;
  assign cmd_ready   = (state_q == IDLE) & PRESETn;
  assign rsp_valid   = state_q == RESP;
  assign PSEL        = (state_q == SETUP) | (state_q == ACCESS);
  assign PENABLE     = state_q == ACCESS;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  // PREADY takes priority, so a completion in the last allowed cycle is not an abort
  assign expire = (TIMEOUT != 0) && !PREADY && (cnt_q == CNT_LAST);
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        if (cmd_addr[1:0] == 2'b00) begin
          state_d  = SETUP;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          cnt_d    = '0;
        end else begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (!PREADY) cnt_d = cnt_q + 1'b1;
        if (PREADY) begin
          state_d = RESP;
          err_d   = PSLVERR;
          to_d    = 1'b0;
          rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else if (expire) begin
          state_d = RESP;
          err_d   = 1'b1;
          to_d    = 1'b1;
          rdata_d = '0;
        end
      end
      default: if (rsp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end
endmodule

// File: tb/tb_rgu_apb_master.sv
// tb_rgu_apb_master: directed and randomized APB transactions checked against a
// transaction-level model of response contents and latency.
module tb_rgu_apb_master;
  localparam int AW = 12, DW = 32, TO = 4;
  logic PCLK = 1'b0, PRESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, PRDATA = '0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, PWRITE, PSEL, PENABLE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;
  int checks = 0, failures = 0;
  typedef struct {
    logic          err;
    logic          to;
    logic [DW-1:0] rdata;
    int            lat;
  } rsp_t;
  rgu_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  // waits = PREADY-low ACCESS cycles before PREADY rises; lat = cycles after handshake until rsp_valid
  function automatic rsp_t model(input logic [AW-1:0] a, input logic w, input int waits,
                                 input logic se, input logic [DW-1:0] rd);
    rsp_t r;
    if (a[1:0] != 2'b00) begin
      r.err = 1'b1; r.to = 1'b0; r.rdata = '0; r.lat = 1;
    end else if (TO != 0 && waits >= TO) begin
      r.err = 1'b1; r.to = 1'b1; r.rdata = '0; r.lat = 2 + TO;
    end else begin
      r.err = se; r.to = 1'b0; r.rdata = (!w && !se) ? rd : '0; r.lat = 3 + waits;
    end
    return r;
  endfunction
  task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                     input int waits, input logic se, input logic [DW-1:0] rd, input int hold);
    rsp_t e;
    int cyc;
    e = model(a, w, waits, se, rd);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = wd;
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_write = 1'($urandom);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      check("psel_active", 64'(PSEL), 64'(1));
      check("penable_phase", 64'(PENABLE), 64'(cyc >= 2));
      check("paddr_stable", 64'(PADDR), 64'(a));
      check("pwrite_stable", 64'(PWRITE), 64'(w));
      check("pwdata_stable", 64'(PWDATA), 64'(wd));
      if (cyc >= 2) begin
        PREADY  = (cyc - 2 == waits);
        PSLVERR = PREADY ? se : 1'($urandom);
        PRDATA  = PREADY ? rd : $urandom;
      end else begin
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
      tick();
      PREADY = 1'b0; PSLVERR = 1'b0;
      cyc++;
    end
    check("rsp_latency", 64'(cyc), 64'(e.lat));
    check("psel_after", 64'(PSEL), 64'(0));
    check("penable_after", 64'(PENABLE), 64'(0));
    check("rsp_err", 64'(rsp_err), 64'(e.err));
    check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      check("hold_psel", 64'(PSEL), 64'(0));
      check("hold_fields", {rsp_err, rsp_timeout, 30'd0, rsp_rdata}, {e.err, e.to, 30'd0, e.rdata});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    check("cmd_ready_back", 64'(cmd_ready), 64'(1));
    check("fields_kept", {rsp_err, rsp_timeout, 30'd0, rsp_rdata}, {e.err, e.to, 30'd0, e.rdata});
  endtask
  initial begin
    int last, n;
    logic [AW-1:0] a;
    tick();
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwrite", 64'(PWRITE), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, 29'd0, rsp_rdata}, 64'(0));
    PRESETn = 1'b1;
    #1;
    txn(12'h010, 1'b1, 32'h0000_00A5, 0, 1'b0, 32'h0, 0);
    txn(12'h004, 1'b0, 32'h0, 3, 1'b0, 32'h0000_0002, 0);
    txn(12'h0FC, 1'b0, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 0);
    txn(12'h020, 1'b0, 32'h0, 1000, 1'b0, 32'h0, 0);
    txn(12'h024, 1'b1, 32'h1234_5678, 1, 1'b0, 32'h0, 0);
    txn(12'h006, 1'b1, 32'hCAFE_0001, 0, 1'b0, 32'h0, 5);
    for (int k = 0; k < 60; k++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      txn(a, 1'($urandom), $urandom, $urandom_range(0, 6), 1'($urandom_range(0, 3) == 0),
          $urandom, $urandom_range(0, 3));
    end
    cmd_valid = 1'b1; cmd_addr = 12'h040; cmd_write = 1'b1; cmd_wdata = 32'h5555_AAAA;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_access", 64'(PENABLE), 64'(1));
    PRESETn = 1'b0;
    tick();
    check("mid_rst_psel", 64'(PSEL), 64'(0));
    check("mid_rst_penable", 64'(PENABLE), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    PRESETn = 1'b1;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_rsp", {62'd0, rsp_valid, PSEL}, 64'(0));
    end
    cmd_valid = 1'b1; rsp_ready = 1'b1; PREADY = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h080;
    last = -1;
    n = 0;
    for (int c = 0; c < 13; c++) begin
      if (cmd_ready) begin
        if (last >= 0) check("b2b_period", 64'(c - last), 64'(4));
        last = c;
        n++;
      end
      cmd_wdata = $urandom;
      tick();
    end
    check("b2b_count", 64'(n), 64'(4));
    cmd_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rgu_apb_master.md
# rgu_apb_master

APB requester that drives the register bus of the reset generation unit (RGU) from a simple valid/ready command port. Firmware-side agents (boot sequencer, debug bridge) use it to program RGU timers and software-reset registers and to read back reset status. It issues one APB transfer at a time. It owns the SETUP/ACCESS phasing, PREADY wait states, PSLVERR capture and a wait-state timeout, and returns one response per command.

## Interface
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 255, maximum ACCESS-phase cycles without PREADY before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  synchronous active-low reset, sampled on PCLK rising edge
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_addr  in  ADDR_W  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR seen, timeout, or misaligned address
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error, valid only with PREADY

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- Reset (PRESETn low at an edge): state IDLE.
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - Timeout counter cleared.
  - cmd_ready=0 while PRESETn is low.
- cmd_ready = (state==IDLE) & PRESETn. It is decoded from the state register and never depends on cmd_valid.
- IDLE, handshake with cmd_addr[1:0]==0:
  - Latch PADDR, PWRITE, PWDATA.
  - Go to SETUP.
- IDLE, handshake with cmd_addr[1:0]!=0:
  - No APB activity.
  - Go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- SETUP: PSEL=1, PENABLE=0. Next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Counter increments each cycle PREADY is low.
  - PREADY=1 → RESP. Capture rsp_err=PSLVERR and rsp_timeout=0. rsp_rdata=PRDATA if read and PSLVERR=0, otherwise 0.
  - PREADY=0 and counter==TIMEOUT-1 with TIMEOUT!=0 → RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- RESP: rsp_valid=1 and all response fields held stable.
  - PSEL=0, PENABLE=0.
  - On rsp_ready → IDLE; rsp_valid drops. rsp_rdata, rsp_err and rsp_timeout keep their values until the next capture.
- PADDR, PWRITE and PWDATA are held constant from SETUP through the end of ACCESS. They keep their last values in IDLE and RESP.
- The counter clears on entry to SETUP. Counter width is ceil(log2(TIMEOUT+1)), minimum 1 bit.
- Exactly one response per accepted command, in order. No new command is accepted while a response is pending.

## Timing
- Command handshake at edge T → SETUP visible in cycle T+1 → ACCESS in cycle T+2.
- Zero-wait slave (PREADY=1 in the first ACCESS cycle): rsp_valid rises in cycle T+3.
- Minimum command-to-command period with rsp_ready tied high: 4 cycles.
- Each cycle of PREADY=0 in ACCESS adds one cycle of latency.
- Timeout: with TIMEOUT=N, an abort leaves ACCESS after exactly N ACCESS cycles with PREADY low. PSEL and PENABLE fall in the following cycle.
- PREADY=1 in the same cycle the timeout would fire: PREADY wins, giving a normal completion.
- PSLVERR and PRDATA are ignored in any cycle where PREADY=0 or the state is not ACCESS.
- Misaligned command: rsp_valid in cycle T+1; PSEL stays 0 throughout.
- Reset mid-transfer: at the reset edge PSEL and PENABLE go to 0. The transfer is dropped with no response. The first cycle after PRESETn returns high is IDLE with cmd_ready=1.

## Test plan
- Write 0x0000_00A5 to 0x010, slave with zero wait states:
  - PSEL high in T+1 and T+2, PENABLE high only in T+2.
  - rsp_valid in T+3 with rsp_err=0 and rsp_rdata=0.
- Read 0x004, slave inserts 3 wait states and returns PRDATA=0x0000_0002:
  - ACCESS lasts 4 cycles.
  - Response is rdata=0x2, err=0; the address is stable throughout.
- Read 0x0FC, slave asserts PREADY=1 and PSLVERR=1:
  - rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT=4, slave never asserts PREADY:
  - Exactly 4 ACCESS cycles, then PSEL=0.
  - Response is err=1, timeout=1; a second command is accepted afterwards.
- Misaligned address 0x006, then rsp_ready held low for 5 cycles:
  - No PSEL activity; rsp_valid and its fields stay stable for 5 cycles.
  - cmd_ready=0 until the response is consumed.
- Drop PRESETn during ACCESS of a write:
  - PSEL, PENABLE and rsp_valid are 0 at the next edge and no response appears.
  - Back-to-back writes after release each complete 4 cycles apart.
